// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC sequencing, 2-entry {PC, Instruction} buffer, RUN/HALT control.
// Optional FETCH_PERF_EN adds saturating FetchCount/StallCount performance counters.

package fetch_controller_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned PERF_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;
endpackage

module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0]  PC_RESET  = 32'd0,
    parameter int unsigned  MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] ReadAddress,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddress,
    output logic        FetchValid,
    input  logic        FetchReady,
    output logic [31:0] FetchInstruction,
    output logic [31:0] FetchPC,
    output logic        FetchDone
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] FetchCount,
    output logic [15:0] StallCount
`endif
);

    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    fetch_entry_t       head_q, head_d;
    fetch_entry_t       tail_q, tail_d;
    fetch_entry_t       new_entry;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               pop;
    logic               push;
    logic [ADDR_W-1:0]  pc_inc;

    assign ReadAddress      = pc_q;
    assign FetchValid       = valid_q;
    assign FetchInstruction = head_q.instr;
    assign FetchPC          = head_q.pc;
    assign FetchDone        = done_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= PC_RESET;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state: redirect wins over push/pop; the buffer shifts so the head is always slot 0
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        pc_inc    = pc_q + ADDR_W'(1);
        new_entry = '{pc: pc_q, instr: Instruction};
        pop       = valid_q && FetchReady;
        push      = (state_q == ST_RUN) && !Stall && !Redirect
                    && ((count_q < CNT_W'(2)) || pop);

        if (Redirect) begin
            count_d = '0;
            if (RedirectAddress < DEPTH) begin
                pc_d    = RedirectAddress;
                state_d = ST_RUN;
            end else begin
                // Out-of-range targets park the PC at the end of memory
                pc_d    = DEPTH;
                state_d = ST_HALT;
            end
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == CNT_W'(0)) begin
                        head_d = new_entry;
                    end else begin
                        tail_d = new_entry;
                    end
                    count_d = count_q + CNT_W'(1);
                end
                2'b01: begin
                    if (count_q == CNT_W'(2)) begin
                        head_d = tail_q;
                    end
                    count_d = count_q - CNT_W'(1);
                end
                2'b11: begin
                    if (count_q == CNT_W'(1)) begin
                        head_d = new_entry;
                    end else begin
                        head_d = tail_q;
                        tail_d = new_entry;
                    end
                end
                default: ;
            endcase

            if (push) begin
                pc_d = pc_inc;
                if (pc_inc == DEPTH) begin
                    state_d = ST_HALT;
                end
            end
        end

        valid_d = (count_d != CNT_W'(0));
        done_d  = (state_d == ST_HALT) && (count_d == CNT_W'(0));
    end

`ifdef FETCH_PERF_EN
    logic [PERF_W-1:0] fetch_cnt_q;
    logic [PERF_W-1:0] stall_cnt_q;

    assign FetchCount = fetch_cnt_q;
    assign StallCount = stall_cnt_q;

    // Saturating counters; pops discarded by a redirect are not counted
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && !Redirect && (fetch_cnt_q != {PERF_W{1'b1}})) begin
                fetch_cnt_q <= fetch_cnt_q + PERF_W'(1);
            end
            if ((state_q == ST_RUN) && Stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller against a preloaded IMEM[k] = 32'h1000_0000 + k.

module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic [31:0] ReadAddress;
    logic [31:0] Instruction;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectAddress;
    logic        FetchValid;
    logic        FetchReady;
    logic [31:0] FetchInstruction;
    logic [31:0] FetchPC;
    logic        FetchDone;
`ifdef FETCH_PERF_EN
    logic [15:0] FetchCount;
    logic [15:0] StallCount;
`endif

    int checks;
    int fails;

    fetch_controller #(.PC_RESET(32'd0), .MEM_DEPTH(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .ReadAddress      (ReadAddress),
        .Instruction      (Instruction),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectAddress  (RedirectAddress),
        .FetchValid       (FetchValid),
        .FetchReady       (FetchReady),
        .FetchInstruction (FetchInstruction),
        .FetchPC          (FetchPC),
        .FetchDone        (FetchDone)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount       (FetchCount),
        .StallCount       (StallCount)
`endif
    );

    // Combinational instruction memory
    assign Instruction = 32'h1000_0000 + ReadAddress;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic ready);
        reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectAddress = 32'd0; FetchReady = ready;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        checks++; if (FetchValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", FetchValid); end
        checks++; if (FetchPC !== 32'd0) begin fails++; $display("FAIL reset_pc: got %h want 0", FetchPC); end
        checks++; if (FetchInstruction !== 32'd0) begin fails++; $display("FAIL reset_instr: got %h want 0", FetchInstruction); end
        checks++; if (FetchDone !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", FetchDone); end
        checks++; if (ReadAddress !== 32'd0) begin fails++; $display("FAIL reset_raddr: got %h want 0", ReadAddress); end
`ifdef FETCH_PERF_EN
        checks++; if (FetchCount !== 16'd0) begin fails++; $display("FAIL reset_fcnt: got %0d want 0", FetchCount); end
        checks++; if (StallCount !== 16'd0) begin fails++; $display("FAIL reset_scnt: got %0d want 0", StallCount); end
`endif
    endtask

    task automatic test_streaming();
        logic [31:0] exp_instr;
        apply_reset(1'b1);
        // First cycle out of reset fetches PC 0; it becomes head one cycle later
        for (int k = 0; k <= 10; k++) begin
            step();
            exp_instr = 32'h1000_0000 + 32'(k);
            checks++; if (FetchValid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %b want 1", k, FetchValid); end
            checks++; if (FetchPC !== 32'(k)) begin fails++; $display("FAIL stream_pc[%0d]: got %0d want %0d", k, FetchPC, k); end
            checks++; if (FetchInstruction !== exp_instr) begin fails++; $display("FAIL stream_instr[%0d]: got %h want %h", k, FetchInstruction, exp_instr); end
            checks++; if (ReadAddress !== 32'(k + 1)) begin fails++; $display("FAIL stream_raddr[%0d]: got %0d want %0d", k, ReadAddress, k + 1); end
        end
`ifdef FETCH_PERF_EN
        checks++; if (FetchCount !== 16'd10) begin fails++; $display("FAIL perf_fetch_count: got %0d want 10", FetchCount); end
        checks++; if (StallCount !== 16'd0) begin fails++; $display("FAIL perf_stall_zero: got %0d want 0", StallCount); end
`endif
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        for (int c = 0; c < 5; c++) begin
            step();
        end
        checks++; if (FetchValid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b want 1", FetchValid); end
        checks++; if (FetchPC !== 32'd0) begin fails++; $display("FAIL bp_head: got %0d want 0", FetchPC); end
        checks++; if (ReadAddress !== 32'd2) begin fails++; $display("FAIL bp_raddr_hold: got %0d want 2", ReadAddress); end
        FetchReady = 1'b1;
        // Full buffer with simultaneous pop and push keeps order
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (FetchPC !== 32'(k)) begin fails++; $display("FAIL bp_order[%0d]: got %0d want %0d", k, FetchPC, k); end
            checks++; if (FetchInstruction !== 32'h1000_0000 + 32'(k)) begin fails++; $display("FAIL bp_instr[%0d]: got %h want %h", k, FetchInstruction, 32'h1000_0000 + 32'(k)); end
        end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        step(); step(); step();
        checks++; if (ReadAddress !== 32'd2) begin fails++; $display("FAIL rd_full_raddr: got %0d want 2", ReadAddress); end
        Redirect = 1'b1; RedirectAddress = 32'd40;
        step();
        Redirect = 1'b0;
        checks++; if (FetchValid !== 1'b0) begin fails++; $display("FAIL rd_flush_valid: got %b want 0", FetchValid); end
        checks++; if (ReadAddress !== 32'd40) begin fails++; $display("FAIL rd_raddr: got %0d want 40", ReadAddress); end
        step();
        checks++; if (FetchValid !== 1'b1) begin fails++; $display("FAIL rd_head_valid: got %b want 1", FetchValid); end
        checks++; if (FetchPC !== 32'd40) begin fails++; $display("FAIL rd_head_pc: got %0d want 40", FetchPC); end
        checks++; if (FetchInstruction !== 32'h1000_0028) begin fails++; $display("FAIL rd_head_instr: got %h want 10000028", FetchInstruction); end
        checks++; if (FetchDone !== 1'b0) begin fails++; $display("FAIL rd_done: got %b want 0", FetchDone); end
    endtask

    task automatic test_end_of_memory();
        apply_reset(1'b0);
        Redirect = 1'b1; RedirectAddress = 32'd62;
        step();
        Redirect = 1'b0;
        step(); step(); step();
        checks++; if (ReadAddress !== 32'd64) begin fails++; $display("FAIL eom_pc_park: got %0d want 64", ReadAddress); end
        checks++; if (FetchPC !== 32'd62) begin fails++; $display("FAIL eom_head62: got %0d want 62", FetchPC); end
        checks++; if (FetchDone !== 1'b0) begin fails++; $display("FAIL eom_done_early: got %b want 0", FetchDone); end
        FetchReady = 1'b1;
        step();
        checks++; if (FetchPC !== 32'd63) begin fails++; $display("FAIL eom_head63: got %0d want 63", FetchPC); end
        checks++; if (FetchInstruction !== 32'h1000_003F) begin fails++; $display("FAIL eom_instr63: got %h want 1000003f", FetchInstruction); end
        checks++; if (FetchDone !== 1'b0) begin fails++; $display("FAIL eom_done_one_left: got %b want 0", FetchDone); end
        step();
        checks++; if (FetchValid !== 1'b0) begin fails++; $display("FAIL eom_empty: got %b want 0", FetchValid); end
        checks++; if (FetchDone !== 1'b1) begin fails++; $display("FAIL eom_done: got %b want 1", FetchDone); end
        step();
        checks++; if (ReadAddress !== 32'd64 || FetchValid !== 1'b0) begin fails++; $display("FAIL eom_halt_hold: got raddr %0d valid %b want 64 0", ReadAddress, FetchValid); end
        // HALT -> RUN via in-range redirect, then an out-of-range redirect halts again
        Redirect = 1'b1; RedirectAddress = 32'd10;
        step();
        checks++; if (FetchDone !== 1'b0) begin fails++; $display("FAIL eom_restart_done: got %b want 0", FetchDone); end
        RedirectAddress = 32'd70;
        step();
        Redirect = 1'b0;
        checks++; if (FetchDone !== 1'b1) begin fails++; $display("FAIL eom_redirect70_done: got %b want 1", FetchDone); end
        step();
        checks++; if (FetchValid !== 1'b0) begin fails++; $display("FAIL eom_halt_nopush: got %b want 0", FetchValid); end
    endtask

    task automatic test_stall_reset();
        apply_reset(1'b0);
        step(); step();
        Stall = 1'b1; FetchReady = 1'b1;
        step();
        checks++; if (FetchPC !== 32'd1 || FetchValid !== 1'b1) begin fails++; $display("FAIL st_drain1: got pc %0d valid %b want 1 1", FetchPC, FetchValid); end
        checks++; if (ReadAddress !== 32'd2) begin fails++; $display("FAIL st_hold1: got %0d want 2", ReadAddress); end
        step();
        checks++; if (FetchValid !== 1'b0) begin fails++; $display("FAIL st_drained: got %b want 0", FetchValid); end
        step();
        checks++; if (ReadAddress !== 32'd2) begin fails++; $display("FAIL st_hold3: got %0d want 2", ReadAddress); end
`ifdef FETCH_PERF_EN
        checks++; if (StallCount !== 16'd3) begin fails++; $display("FAIL perf_stall_count: got %0d want 3", StallCount); end
`endif
        Stall = 1'b0;
        step();
        checks++; if (FetchPC !== 32'd2 || FetchValid !== 1'b1) begin fails++; $display("FAIL st_resume: got pc %0d valid %b want 2 1", FetchPC, FetchValid); end
        step();
        checks++; if (FetchPC !== 32'd3) begin fails++; $display("FAIL st_stream: got %0d want 3", FetchPC); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (FetchValid !== 1'b0) begin fails++; $display("FAIL st_reset_valid: got %b want 0", FetchValid); end
        checks++; if (ReadAddress !== 32'd0) begin fails++; $display("FAIL st_reset_raddr: got %0d want 0", ReadAddress); end
        checks++; if (FetchPC !== 32'd0) begin fails++; $display("FAIL st_reset_pc: got %0d want 0", FetchPC); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectAddress = 32'd0; FetchReady = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_end_of_memory();
        test_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter PC_RESET, default 0: word address fetched first after reset.
REQ-002 SHALL have parameter MEM_DEPTH, default 64: number of instruction words; valid addresses are 0..MEM_DEPTH-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ReadAddress, output, 32 bits: word index to the combinational instruction memory.
REQ-006 SHALL have port Instruction, input, 32 bits: memory read data for ReadAddress, valid in the same cycle.
REQ-007 SHALL have port Stall, input, 1 bit: suppresses new fetches while high.
REQ-008 SHALL have port Redirect, input, 1 bit: one-cycle request to restart fetch at RedirectAddress.
REQ-009 SHALL have port RedirectAddress, input, 32 bits: new word address.
REQ-010 SHALL have port FetchValid, output, 1 bit: FetchInstruction and FetchPC are valid.
REQ-011 SHALL have port FetchReady, input, 1 bit: consumer accepts the head entry.
REQ-012 SHALL have port FetchInstruction, output, 32 bits: head instruction.
REQ-013 SHALL have port FetchPC, output, 32 bits: word address of the head instruction.
REQ-014 SHALL have port FetchDone, output, 1 bit: state is HALT and the buffer is empty.

Function
REQ-015 SHALL keep a 32-bit PC and drive ReadAddress = PC combinationally at all times.
REQ-016 SHALL have states RUN and HALT.
- RUN -> HALT when PC+1 == MEM_DEPTH on a push, or on a redirect to an address >= MEM_DEPTH.
- HALT -> RUN only on a redirect to an address < MEM_DEPTH.
REQ-017 SHALL hold a 2-entry FIFO of {PC, Instruction} pairs. Head drives FetchInstruction and FetchPC.
REQ-018 SHALL define pop as FetchValid && FetchReady.
REQ-019 SHALL define push as state==RUN && !Stall && !Redirect && (count<2 || pop). On a push, {PC, Instruction} is written to the tail and PC <= PC+1.
REQ-020 SHALL support a simultaneous push and pop when full; count stays 2 and order is preserved.
REQ-021 SHALL give latency 1: an instruction fetched at address A in cycle n is presentable as head in cycle n+1 at the earliest.
REQ-022 SHALL assert FetchValid iff count>0. Once asserted, head contents SHALL NOT change until a pop, redirect or reset.
REQ-023 On Redirect, SHALL empty the FIFO (count<=0), set PC <= RedirectAddress, perform no push, and ignore any pop in that cycle. Redirect has priority over push, pop and Stall.
REQ-024 SHALL leave PC and the FIFO unchanged by Stall, except that pops continue.
REQ-025 SHALL keep PC at MEM_DEPTH in HALT and perform no pushes there.
REQ-026 SHALL make FetchDone = (state==HALT) && (count==0).
REQ-027 SHALL keep address arithmetic unsigned 32-bit; the PC never wraps past MEM_DEPTH.

Reset
REQ-028 On reset high at a clock edge, SHALL set PC=PC_RESET, state=RUN, count=0, FetchValid=0, FetchInstruction=0, FetchPC=0 and FetchDone=0. ReadAddress then equals PC_RESET.
REQ-029 SHALL give reset priority over Redirect, Stall and handshakes. Reset mid-operation discards buffered entries with no pop reported.

Configuration
REQ-030 With FETCH_PERF_EN defined, SHALL add outputs FetchCount[15:0] and StallCount[15:0], both reset to 0.
- FetchCount increments on each pop.
- StallCount increments each cycle with state==RUN and Stall high.
- Both saturate at 16'hFFFF.
REQ-031 Without FETCH_PERF_EN, the ports and counters SHALL be absent, with no other behavioural change.

Verification
Memory model preloaded with IMEM[k] = 32'h1000_0000+k; MEM_DEPTH=64.
REQ-032 SHALL cover streaming: release reset with FetchReady=1 -> FetchValid rises in cycle 2 with FetchPC=0 and FetchInstruction=32'h1000_0000, then one entry per cycle with PC 1, 2, 3.
REQ-033 SHALL cover backpressure: FetchReady=0 for 5 cycles -> count reaches 2, ReadAddress holds 2, head stays PC 0; after FetchReady=1, PCs 0, 1, 2 emerge in order with no loss.
REQ-034 SHALL cover redirect: Redirect=1 with RedirectAddress=40 while full -> next cycle FetchValid=0 and ReadAddress=40; the following cycle head is PC 40 with 32'h1000_0028.
REQ-035 SHALL cover the end of memory: redirect to 62 -> PCs 62 and 63 delivered, state HALT, FetchDone=1 after both pops; a redirect to 70 gives HALT with FetchDone=1 one cycle later.
REQ-036 SHALL cover stall with reset: Stall=1 for 3 cycles -> no PC advance while the FIFO drains; reset asserted mid-stream -> next cycle FetchValid=0 and ReadAddress=PC_RESET.
REQ-037 With FETCH_PERF_EN, SHALL check after REQ-032 plus 10 pops: FetchCount=10; 3 stall cycles give StallCount=3.
